ac97_frame_receiver: RTL and testbench

//  Synthesizable codec-side AC97 frame receiver on bit_clk. Deserialises sdata_out

---
 rtl/ac97_frame_receiver.sv | 253 +++++++++++++++++++++++++
 tb/tb_ac97_frame_receiver.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_frame_receiver.sv
// ---------------------------------------------------------------------------
// ac97_frame_receiver
//
// Codec-side AC97 frame receiver. Watches SYNC for a rising edge, then
// deserialises 256 bits of sdata_out (MSB first) into the slot 0 tag, the
// command/address (slot 1) and command data (slot 2) words, and NUM_CH PCM
// slots starting at slot 3. Register write/read requests and PCM samples are
// handed to downstream sinks as one-cycle pulses. SYNC width and frame length
// are checked, and violations raise sticky error flags.
//
// Parameters:
//   NUM_CH      PCM channels captured (1..10); channel i lives in slot 3+i and
//               is flagged valid by tag bit 12-i
//   PCM_WIDTH   bits kept per PCM slot (1..20), taken from the slot MSBs
//   CHECK_SYNC  nonzero enables the SYNC high-width check
//
// Ports:
//   bit_clk     AC97 bit clock, all logic on the rising edge
//   reset_b     asynchronous active-low reset
//   sync        AC97 SYNC
//   sdata_out   serial frame data, MSB first
//   err_clr     clears sync_err and frame_err
//   tag         slot 0 of the most recent frame
//   tag_strobe  one-cycle pulse when tag updates
//   reg_wr_en   one-cycle register write pulse
//   reg_rd_req  one-cycle register read-request pulse
//   reg_addr    slot1[18:12]
//   reg_wdata   slot2[19:4]
//   pcm_data    captured PCM fields, ch0 in the LSBs, held between strobes
//   pcm_valid   per-channel valid, qualified by pcm_strobe
//   pcm_strobe  one-cycle pulse after the last PCM slot
//   frame_cnt   completed frame count, wraps
//   sync_err    sticky, bad SYNC width
//   frame_err   sticky, frame length other than 256 bits
// ---------------------------------------------------------------------------
module ac97_frame_receiver #(
  parameter int NUM_CH     = 2,
  parameter int PCM_WIDTH  = 20,
  parameter int CHECK_SYNC = 1
) (
  input  logic                        bit_clk,
  input  logic                        reset_b,
  input  logic                        sync,
  input  logic                        sdata_out,
  input  logic                        err_clr,
  output logic [15:0]                 tag,
  output logic                        tag_strobe,
  output logic                        reg_wr_en,
  output logic                        reg_rd_req,
  output logic [6:0]                  reg_addr,
  output logic [15:0]                 reg_wdata,
  output logic [NUM_CH*PCM_WIDTH-1:0] pcm_data,
  output logic [NUM_CH-1:0]           pcm_valid,
  output logic                        pcm_strobe,
  output logic [15:0]                 frame_cnt,
  output logic                        sync_err,
  output logic                        frame_err
);

  localparam int  PcmBits     = NUM_CH * PCM_WIDTH;
  localparam bit  SyncCheckEn = (CHECK_SYNC != 0);
  localparam logic [8:0] FrameLen  = 9'd256;
  localparam logic [8:0] StrobeBit = 9'(55 + 20 * NUM_CH);

  typedef enum logic {
    IDLE,
    FRAME
  } state_e;

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               sync_q;
  logic               rise;
  logic               sampleEn;
  logic [8:0]         bitIdx;
  logic               frameDone;
  logic               lenErr;
  logic               syncBad;
  logic [19:0]        sr_q;
  logic [19:0]        srNext;
  logic [19:0]        slot1_q;
  logic [PcmBits-1:0] pcmStage_q, pcmStage_d;
  logic [NUM_CH-1:0]  validNext;
  logic               hitTag, hitSlot1, hitSlot2, hitStrobe;

  logic [15:0]        tag_q;
  logic               tagStrobe_q;
  logic               regWrEn_q;
  logic               regRdReq_q;
  logic [6:0]         regAddr_q;
  logic [15:0]        regWdata_q;
  logic [PcmBits-1:0] pcmData_q;
  logic [NUM_CH-1:0]  pcmValid_q;
  logic               pcmStrobe_q;
  logic [15:0]        frameCnt_q;
  logic               syncErr_q;
  logic               frameErr_q;

  assign rise = sync & ~sync_q;

  // Frame sequencing. A SYNC rise always samples frame bit 0 and restarts the
  // counter at 1; whether that rise also completes the previous frame or
  // truncates it depends on whether the counter had reached 256. A frame that
  // reaches 256 with no following rise is still counted but flagged.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sampleEn  = 1'b0;
    bitIdx    = 9'd0;
    frameDone = 1'b0;
    lenErr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = FRAME;
          cnt_d    = 9'd1;
          sampleEn = 1'b1;
        end
      end
      FRAME: begin
        if (rise) begin
          cnt_d    = 9'd1;
          sampleEn = 1'b1;
          if (cnt_q == FrameLen) begin
            frameDone = 1'b1;
          end else begin
            lenErr = 1'b1;
          end
        end else if (cnt_q == FrameLen) begin
          frameDone = 1'b1;
          lenErr    = 1'b1;
          state_d   = IDLE;
          cnt_d     = 9'd0;
        end else begin
          sampleEn = 1'b1;
          bitIdx   = cnt_q;
          cnt_d    = cnt_q + 9'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 9'd0;
      end
    endcase
  end

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot boundaries are decoded from the bit index of the sample being taken
  // this cycle, and results are loaded from the shift register's next value so
  // that each slot becomes visible exactly one cycle after its last bit.
  always_comb begin
    srNext     = {sr_q[18:0], sdata_out};
    hitTag     = sampleEn && (bitIdx == 9'd15);
    hitSlot1   = sampleEn && (bitIdx == 9'd35);
    hitSlot2   = sampleEn && (bitIdx == 9'd55);
    hitStrobe  = sampleEn && (bitIdx == StrobeBit);
    syncBad    = SyncCheckEn && sampleEn &&
                 (((bitIdx >= 9'd1) && (bitIdx <= 9'd15) && !sync) ||
                  ((bitIdx == 9'd16) && sync));
    pcmStage_d = pcmStage_q;
    validNext  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sampleEn && (bitIdx == 9'(75 + 20 * i))) begin
        pcmStage_d[i*PCM_WIDTH +: PCM_WIDTH] = srNext[19 -: PCM_WIDTH];
      end
      validNext[i] = tag_q[15] & tag_q[12-i];
    end
  end

  // Datapath and output registers. Pulses default low every cycle, so a frame
  // cut short by an early SYNC rise or reset never reaches the bit that would
  // raise its outstanding pulses. The error flags clear on err_clr but a new
  // error in the same cycle wins.
  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q      <= 1'b0;
      sr_q        <= '0;
      slot1_q     <= '0;
      pcmStage_q  <= '0;
      tag_q       <= '0;
      tagStrobe_q <= 1'b0;
      regWrEn_q   <= 1'b0;
      regRdReq_q  <= 1'b0;
      regAddr_q   <= '0;
      regWdata_q  <= '0;
      pcmData_q   <= '0;
      pcmValid_q  <= '0;
      pcmStrobe_q <= 1'b0;
      frameCnt_q  <= '0;
      syncErr_q   <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      sync_q      <= sync;
      tagStrobe_q <= 1'b0;
      regWrEn_q   <= 1'b0;
      regRdReq_q  <= 1'b0;
      pcmStrobe_q <= 1'b0;
      pcmStage_q  <= pcmStage_d;
      if (sampleEn) begin
        sr_q <= srNext;
      end
      if (hitTag) begin
        tag_q       <= srNext[15:0];
        tagStrobe_q <= 1'b1;
      end
      if (hitSlot1) begin
        slot1_q <= srNext;
      end
      if (hitSlot2 && tag_q[15] && tag_q[14]) begin
        regAddr_q  <= slot1_q[18:12];
        regWdata_q <= srNext[19:4];
        if (slot1_q[19]) begin
          regRdReq_q <= 1'b1;
        end else if (tag_q[13]) begin
          regWrEn_q <= 1'b1;
        end
      end
      if (hitStrobe && tag_q[15]) begin
        pcmData_q   <= pcmStage_d;
        pcmValid_q  <= validNext;
        pcmStrobe_q <= 1'b1;
      end
      if (frameDone) begin
        frameCnt_q <= frameCnt_q + 16'd1;
      end
      syncErr_q  <= (syncErr_q & ~err_clr) | syncBad;
      frameErr_q <= (frameErr_q & ~err_clr) | lenErr;
    end
  end

  assign tag        = tag_q;
  assign tag_strobe = tagStrobe_q;
  assign reg_wr_en  = regWrEn_q;
  assign reg_rd_req = regRdReq_q;
  assign reg_addr   = regAddr_q;
  assign reg_wdata  = regWdata_q;
  assign pcm_data   = pcmData_q;
  assign pcm_valid  = pcmValid_q;
  assign pcm_strobe = pcmStrobe_q;
  assign frame_cnt  = frameCnt_q;
  assign sync_err   = syncErr_q;
  assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ac97_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_ac97_frame_receiver
//
// Drives whole AC97 frames built from a tag and twelve 20-bit slot values.
// For each frame a frame-level reference model decides which pulses must
// appear (tag, register write/read, PCM) and pushes them into queues; an
// independent monitor pops and compares whenever the receiver pulses. Frame
// count and sticky error flags are tracked by the same model and compared at
// bit 20 of every frame and after idle gaps.
// ---------------------------------------------------------------------------
module tb_ac97_frame_receiver;

  localparam int NUM_CH    = 2;
  localparam int PCM_WIDTH = 20;
  localparam int PW        = NUM_CH * PCM_WIDTH;

  logic            bit_clk = 1'b0;
  logic            reset_b;
  logic            sync;
  logic            sdata_out;
  logic            err_clr;
  logic [15:0]     tag;
  logic            tag_strobe;
  logic            reg_wr_en;
  logic            reg_rd_req;
  logic [6:0]      reg_addr;
  logic [15:0]     reg_wdata;
  logic [PW-1:0]   pcm_data;
  logic [NUM_CH-1:0] pcm_valid;
  logic            pcm_strobe;
  logic [15:0]     frame_cnt;
  logic            sync_err;
  logic            frame_err;

  ac97_frame_receiver #(
    .NUM_CH(NUM_CH),
    .PCM_WIDTH(PCM_WIDTH),
    .CHECK_SYNC(1)
  ) dut (
    .bit_clk(bit_clk),
    .reset_b(reset_b),
    .sync(sync),
    .sdata_out(sdata_out),
    .err_clr(err_clr),
    .tag(tag),
    .tag_strobe(tag_strobe),
    .reg_wr_en(reg_wr_en),
    .reg_rd_req(reg_rd_req),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .pcm_data(pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_strobe(pcm_strobe),
    .frame_cnt(frame_cnt),
    .sync_err(sync_err),
    .frame_err(frame_err)
  );

  always #5 bit_clk = ~bit_clk;

  typedef struct {
    logic [1:0]  kind;
    logic [6:0]  addr;
    logic [15:0] wdata;
  } regEv_t;

  typedef struct {
    logic [PW-1:0]     data;
    logic [NUM_CH-1:0] valid;
  } pcmEv_t;

  localparam logic [1:0] KindWr = 2'b01;
  localparam logic [1:0] KindRd = 2'b10;

  logic [15:0] tagQ[$];
  regEv_t      regQ[$];
  pcmEv_t      pcmQ[$];

  int nCompares    = 0;
  int nMiscompares = 0;

  logic [15:0] mFrameCnt;
  logic        mSyncErr;
  logic        mFrameErr;
  int          prevLen;

  logic [15:0] tagV;
  logic [19:0] slotV [1:12];
  logic        frameBits [0:255];

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompares++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Serial image of a frame: 16-bit tag, then 20-bit slots, all MSB first.
  task automatic buildFrame();
    frameBits[0] = tagV[15];
    for (int b = 0; b < 256; b++) begin
      if (b < 16) begin
        frameBits[b] = tagV[15-b];
      end else begin
        frameBits[b] = slotV[(b + 4) / 20][19 - ((b + 4) % 20)];
      end
    end
  endtask

  // Pulses a frame of nBits sampled bits should produce. A pulse belongs to
  // the frame only if the last bit it depends on was actually sampled.
  task automatic pushExpect(input int nBits);
    regEv_t r;
    pcmEv_t p;
    if (nBits > 15) begin
      tagQ.push_back(tagV);
    end
    if (nBits > 55 && tagV[15] && tagV[14]) begin
      r.addr  = slotV[1][18:12];
      r.wdata = slotV[2][19:4];
      if (slotV[1][19]) begin
        r.kind = KindRd;
        regQ.push_back(r);
      end else if (tagV[13]) begin
        r.kind = KindWr;
        regQ.push_back(r);
      end
    end
    if (nBits > 55 + 20 * NUM_CH && tagV[15]) begin
      p.data  = '0;
      p.valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        p.data[i*PCM_WIDTH +: PCM_WIDTH] = PCM_WIDTH'(slotV[3+i] >> (20 - PCM_WIDTH));
        p.valid[i] = tagV[12-i];
      end
      pcmQ.push_back(p);
    end
  endtask

  task automatic checkFlags(input string where);
    checkOutput({where, " frame_cnt"}, 64'(frame_cnt), 64'(mFrameCnt));
    checkOutput({where, " sync_err"}, 64'(sync_err), 64'(mSyncErr));
    checkOutput({where, " frame_err"}, 64'(frame_err), 64'(mFrameErr));
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, " ctrl outputs"},
                64'({tag, tag_strobe, reg_wr_en, reg_rd_req, reg_addr, reg_wdata, frame_cnt}),
                64'd0);
    checkOutput({where, " pcm/err outputs"},
                64'({pcm_data, pcm_valid, pcm_strobe, sync_err, frame_err}), 64'd0);
  endtask

  task automatic modelReset();
    mFrameCnt = 16'd0;
    mSyncErr  = 1'b0;
    mFrameErr = 1'b0;
    prevLen   = -1;
  endtask

  // Sends one frame of nBits bits with SYNC high for syncHigh bits. err_clr is
  // pulsed at bit clrBit (-1 for none); resetAt >= 0 asserts reset in that bit.
  task automatic applyStimulus(input int nBits, input int syncHigh,
                               input int clrBit, input int resetAt);
    int lastBit;
    lastBit = (resetAt >= 0) ? resetAt : nBits;
    if (clrBit == 0) begin
      mSyncErr  = 1'b0;
      mFrameErr = 1'b0;
    end
    if (prevLen == 256) begin
      mFrameCnt = mFrameCnt + 16'd1;
    end else if (prevLen >= 0) begin
      mFrameErr = 1'b1;
    end
    if (syncHigh != 16) begin
      mSyncErr = 1'b1;
    end
    pushExpect(lastBit);
    buildFrame();
    for (int b = 0; b < lastBit; b++) begin
      if (b == 20) begin
        checkFlags("bit20");
      end
      if (b == clrBit && b != 0) begin
        mSyncErr  = 1'b0;
        mFrameErr = 1'b0;
      end
      err_clr   = (b == clrBit);
      sync      = (b < syncHigh);
      sdata_out = frameBits[b];
      @(posedge bit_clk);
      #1;
    end
    err_clr = 1'b0;
    prevLen = nBits;
    if (resetAt >= 0) begin
      sync    = 1'b0;
      reset_b = 1'b0;
      #1;
      checkAllZero("mid-frame reset");
      modelReset();
      repeat (3) @(posedge bit_clk);
      #1;
      reset_b = 1'b1;
      repeat (2) @(posedge bit_clk);
      #1;
    end
  endtask

  // SYNC held low: a completed frame is counted but flagged as missing SYNC.
  task automatic driveIdle(input int n);
    if (prevLen == 256) begin
      mFrameCnt = mFrameCnt + 16'd1;
      mFrameErr = 1'b1;
    end
    prevLen   = -1;
    sync      = 1'b0;
    sdata_out = 1'b0;
    repeat (n) @(posedge bit_clk);
    #1;
    checkFlags("idle");
  endtask

  task automatic randomSlots();
    for (int s = 1; s <= 12; s++) begin
      slotV[s] = 20'($urandom());
    end
  endtask

  // Monitor: every pulse is matched against the oldest expectation of its kind.
  initial begin
    forever begin
      @(negedge bit_clk);
      if (tag_strobe) begin
        if (tagQ.size() == 0) begin
          checkOutput("spurious tag_strobe", 64'(tag_strobe), 64'd0);
        end else begin
          checkOutput("tag", 64'(tag), 64'(tagQ.pop_front()));
        end
      end
      if (reg_wr_en || reg_rd_req) begin
        if (regQ.size() == 0) begin
          checkOutput("spurious reg pulse", 64'({reg_rd_req, reg_wr_en}), 64'd0);
        end else begin
          regEv_t r;
          r = regQ.pop_front();
          checkOutput("reg pulse kind", 64'({reg_rd_req, reg_wr_en}), 64'(r.kind));
          checkOutput("reg_addr", 64'(reg_addr), 64'(r.addr));
          if (r.kind == KindWr) begin
            checkOutput("reg_wdata", 64'(reg_wdata), 64'(r.wdata));
          end
        end
      end
      if (pcm_strobe) begin
        if (pcmQ.size() == 0) begin
          checkOutput("spurious pcm_strobe", 64'(pcm_strobe), 64'd0);
        end else begin
          pcmEv_t p;
          p = pcmQ.pop_front();
          checkOutput("pcm_data", 64'(pcm_data), 64'(p.data));
          checkOutput("pcm_valid", 64'(pcm_valid), 64'(p.valid));
        end
      end
    end
  end

  initial begin
    int nBits;
    int syncHigh;
    int clrBit;
    reset_b   = 1'b0;
    sync      = 1'b0;
    sdata_out = 1'b0;
    err_clr   = 1'b0;
    modelReset();
    repeat (3) @(posedge bit_clk);
    #1;
    checkAllZero("reset");
    reset_b = 1'b1;
    repeat (2) @(posedge bit_clk);
    #1;

    // Register write: addr 02, data 1F1F.
    randomSlots();
    tagV     = 16'hE000;
    slotV[1] = {1'b0, 7'h02, 12'h000};
    slotV[2] = {16'h1F1F, 4'h0};
    applyStimulus(256, 16, -1, -1);

    // PCM on both channels.
    randomSlots();
    tagV     = 16'h9800;
    slotV[3] = 20'h12345;
    slotV[4] = 20'hFEDCB;
    applyStimulus(256, 16, -1, -1);

    // Invalid frame: tag only, still counted.
    randomSlots();
    tagV     = 16'h7800;
    slotV[1] = {1'b1, 7'h15, 12'h000};
    applyStimulus(256, 16, -1, -1);

    // Register read request.
    randomSlots();
    tagV     = 16'hC000;
    slotV[1] = {1'b1, 7'h7C, 12'h000};
    applyStimulus(256, 16, -1, -1);

    // Early SYNC rise before the PCM slots finish, then a normal frame.
    randomSlots();
    tagV = 16'hF800;
    applyStimulus(90, 16, -1, -1);
    randomSlots();
    tagV = 16'hF800;
    applyStimulus(256, 16, -1, -1);

    // SYNC one bit short, then clear both flags mid-frame.
    randomSlots();
    tagV = 16'hE800;
    applyStimulus(256, 15, -1, -1);
    randomSlots();
    tagV = 16'hE800;
    applyStimulus(256, 16, 30, -1);

    // SYNC one bit long.
    randomSlots();
    tagV = 16'hA000;
    applyStimulus(256, 17, -1, -1);

    // Short frame, then err_clr coinciding with the frame_err it causes.
    randomSlots();
    tagV = 16'hE000;
    applyStimulus(60, 16, 30, -1);
    randomSlots();
    tagV = 16'hD000;
    applyStimulus(256, 16, 0, -1);

    // Randomised frames.
    for (int n = 0; n < 40; n++) begin
      randomSlots();
      tagV     = 16'($urandom());
      tagV[15] = ($urandom_range(3, 0) != 0);
      nBits    = ($urandom_range(4, 0) == 0) ? int'($urandom_range(255, 24)) : 256;
      case ($urandom_range(5, 0))
        0:       syncHigh = 15;
        1:       syncHigh = 17;
        default: syncHigh = 16;
      endcase
      case ($urandom_range(5, 0))
        0:       clrBit = 0;
        1:       clrBit = 30;
        default: clrBit = -1;
      endcase
      applyStimulus(nBits, syncHigh, clrBit, -1);
    end

    // Full frame followed by missing SYNC.
    randomSlots();
    tagV = 16'hF800;
    applyStimulus(256, 16, -1, -1);
    driveIdle(5);

    // Restart from idle, then reset in the middle of a frame.
    randomSlots();
    tagV = 16'hE000;
    applyStimulus(256, 16, 0, -1);
    randomSlots();
    tagV = 16'hF800;
    applyStimulus(256, 16, -1, 40);

    // After reset the next complete frame is counted as the first.
    randomSlots();
    tagV = 16'hF800;
    applyStimulus(256, 16, -1, -1);
    randomSlots();
    tagV = 16'hE800;
    applyStimulus(256, 16, -1, -1);
    driveIdle(5);

    repeat (4) @(posedge bit_clk);
    #1;
    checkOutput("tag queue drained", 64'(tagQ.size()), 64'd0);
    checkOutput("reg queue drained", 64'(regQ.size()), 64'd0);
    checkOutput("pcm queue drained", 64'(pcmQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
    $finish;
  end

endmodule
